// File: rtl/freqm_gate_counter.sv
// Gate-window frequency counter: counts FX rising edges over GATE_CYC cycles of CLK into a 4-digit BCD result.
// Result lands GATE_CYC+2 cycles after RUN is sampled; there is no backpressure, and VALID is a single-cycle strobe.
module freqm_gate_counter #(
    parameter int unsigned GATE_CYC = 1000
) (
    input  logic        CLK,
    input  logic        nCLR,
    input  logic        RUN,
    input  logic        FX,
    output logic [15:0] Q,
    output logic        OVF,
    output logic        VALID,
    output logic        GATE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam logic [31:0] LAST_CYC = 32'(GATE_CYC - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] timer;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic [15:0] cnt_nxt;
    logic        cnt_carry;
    logic        carry;
    logic        sticky;
    logic        sticky_nxt;
    logic        fx_meta;
    logic        fx_sync;
    logic        fx_prev;
    logic        fx_rise;
    logic        count_en;
    logic        last_cyc;

    // FX is asynchronous: two flops for metastability, a third to find the rising edge.
    always_ff @(negedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            fx_meta <= 1'b0;
            fx_sync <= 1'b0;
            fx_prev <= 1'b0;
        end else begin
            fx_meta <= FX;
            fx_sync <= fx_meta;
            fx_prev <= fx_sync;
        end
    end

    assign fx_rise  = fx_sync & ~fx_prev;
    assign count_en = (state == ST_COUNT) && fx_rise;
    assign last_cyc = (state == ST_COUNT) && (timer == LAST_CYC);

    // Decimal ripple increment: each digit rolls 9 -> 0 and passes the carry upward.
    always_comb begin
        cnt_inc = cnt;
        carry   = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (cnt[4*d +: 4] == 4'd9) begin
                    cnt_inc[4*d +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*d +: 4] = cnt[4*d +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        cnt_carry = carry;
    end

    always_comb begin
        cnt_nxt    = cnt;
        sticky_nxt = sticky;
        if (count_en) begin
            cnt_nxt    = cnt_inc;
            sticky_nxt = sticky | cnt_carry;
        end
    end

    // RUN is only consulted in IDLE and LATCH, so dropping it mid-window lets the window finish.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = RUN ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_nxt = ST_COUNT;
            ST_COUNT: state_nxt = last_cyc ? ST_LATCH : ST_COUNT;
            ST_LATCH: state_nxt = RUN ? ST_CLEAR : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(negedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(negedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            timer  <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    timer  <= '0;
                    cnt    <= '0;
                    sticky <= 1'b0;
                end
                ST_COUNT: begin
                    timer  <= timer + 32'd1;
                    cnt    <= cnt_nxt;
                    sticky <= sticky_nxt;
                end
                default: ;
            endcase
        end
    end

    // Result is captured from the next-count value so an edge in the final COUNT cycle is included.
    always_ff @(negedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            Q   <= '0;
            OVF <= 1'b0;
        end else if (last_cyc) begin
            Q   <= cnt_nxt;
            OVF <= sticky_nxt;
        end
    end

    assign VALID = (state == ST_LATCH);
    assign GATE  = (state == ST_COUNT);

endmodule

// File: tb/tb_freqm_gate_counter.sv
// Bench for freqm_gate_counter: four instances with different gate lengths share the stimulus.
// A cycle-indexed reference works out the windows and BCD results from RUN/FX arithmetic.
`timescale 1ns/1ps
module tb_freqm_gate_counter;

    localparam int unsigned G_A = 100;
    localparam int unsigned G_B = 10;
    localparam int unsigned G_C = 20100;
    localparam int unsigned G_D = 1;

    logic        CLK  = 1'b0;
    logic        nCLR = 1'b0;
    logic        RUN  = 1'b0;
    logic        FX   = 1'b0;
    logic [15:0] q_a, q_b, q_c, q_d;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;
    logic        valid_a, valid_b, valid_c, valid_d;
    logic        gate_a, gate_b, gate_c, gate_d;

    int checks = 0;
    int errors = 0;
    int first_bad;

    bit          run_q[$];
    bit          fx_q[$];
    logic [15:0] obs_q[$];
    logic        obs_ovf[$];
    logic        obs_valid[$];
    logic        obs_gate[$];
    bit          exp_gate[];
    bit          exp_valid[];
    bit          exp_ovf[];
    logic [15:0] exp_q[];

    freqm_gate_counter #(.GATE_CYC(G_A)) u_a (.CLK(CLK), .nCLR(nCLR), .RUN(RUN), .FX(FX),
        .Q(q_a), .OVF(ovf_a), .VALID(valid_a), .GATE(gate_a));
    freqm_gate_counter #(.GATE_CYC(G_B)) u_b (.CLK(CLK), .nCLR(nCLR), .RUN(RUN), .FX(FX),
        .Q(q_b), .OVF(ovf_b), .VALID(valid_b), .GATE(gate_b));
    freqm_gate_counter #(.GATE_CYC(G_C)) u_c (.CLK(CLK), .nCLR(nCLR), .RUN(RUN), .FX(FX),
        .Q(q_c), .OVF(ovf_c), .VALID(valid_c), .GATE(gate_c));
    freqm_gate_counter #(.GATE_CYC(G_D)) u_d (.CLK(CLK), .nCLR(nCLR), .RUN(RUN), .FX(FX),
        .Q(q_d), .OVF(ovf_d), .VALID(valid_d), .GATE(gate_d));

    always #5 CLK = ~CLK;

    function automatic logic [18:0] outs(input int idx);
        case (idx)
            0:       return {gate_a, valid_a, ovf_a, q_a};
            1:       return {gate_b, valid_b, ovf_b, q_b};
            2:       return {gate_c, valid_c, ovf_c, q_c};
            default: return {gate_d, valid_d, ovf_d, q_d};
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic clear_stim();
        run_q.delete();
        fx_q.delete();
    endtask

    task automatic add(input int n, input bit r, input bit f);
        for (int i = 0; i < n; i++) begin
            run_q.push_back(r);
            fx_q.push_back(f);
        end
    endtask

    task automatic add_pulses(input int n, input int hi, input int lo, input bit r);
        for (int i = 0; i < n; i++) begin
            add(hi, r, 1'b1);
            add(lo, r, 1'b0);
        end
    endtask

    // FX toggles in random runs of 1..3 cycles; RUN is high on run_pct percent of cycles.
    task automatic add_random(input int n, input int run_pct);
        bit f;
        int i;
        int len;
        f = (fx_q.size() > 0) ? fx_q[fx_q.size()-1] : 1'b0;
        i = 0;
        while (i < n) begin
            len = int'($urandom_range(1, 3));
            f   = ~f;
            for (int j = 0; j < len && i < n; j++) begin
                run_q.push_back($urandom_range(0, 99) < run_pct);
                fx_q.push_back(f);
                i++;
            end
        end
    endtask

    // Reference: RUN seen in an idle or latch cycle c opens a window whose result appears
    // at c+2+g; FX rises driven in cycles c..c+g-1 land in it (two-cycle synchroniser delay).
    task automatic model(input int g);
        int          n;
        int          c;
        int          cnt;
        logic [15:0] qv;
        bit          ov;
        n = run_q.size();
        exp_gate  = new[n];
        exp_valid = new[n];
        exp_ovf   = new[n];
        exp_q     = new[n];
        for (int k = 0; k < n; k++) exp_q[k] = 16'h0000;
        c = 0;
        while (c < n) begin
            if (run_q[c]) begin
                cnt = 0;
                for (int k = c + 2; k <= c + 1 + g && k < n; k++) exp_gate[k] = 1'b1;
                for (int r = c; r <= c + g - 1 && r < n; r++)
                    if (fx_q[r] && (r == 0 || !fx_q[r-1])) cnt++;
                c = c + 2 + g;
                if (c < n) begin
                    exp_valid[c] = 1'b1;
                    qv = to_bcd(cnt % 10000);
                    ov = (cnt >= 10000);
                    for (int k = c; k < n; k++) begin
                        exp_q[k]   = qv;
                        exp_ovf[k] = ov;
                    end
                end
            end else begin
                c++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        nCLR = 1'b0;
        RUN  = 1'b0;
        FX   = 1'b0;
        repeat (3) @(posedge CLK);
        nCLR = 1'b1;
    endtask

    // Cycle i: sample outputs on the rising edge (DUT updates on falling), then drive cycle i inputs.
    task automatic drive_record(input int idx);
        logic [18:0] o;
        obs_q.delete();
        obs_ovf.delete();
        obs_valid.delete();
        obs_gate.delete();
        foreach (run_q[i]) begin
            @(posedge CLK);
            o = outs(idx);
            obs_gate.push_back(o[18]);
            obs_valid.push_back(o[17]);
            obs_ovf.push_back(o[16]);
            obs_q.push_back(o[15:0]);
            RUN = run_q[i];
            FX  = fx_q[i];
        end
        @(posedge CLK);
        RUN = 1'b0;
        FX  = 1'b0;
    endtask

    function automatic int count_diffs();
        int d;
        d = 0;
        first_bad = -1;
        foreach (obs_q[i]) begin
            if (obs_gate[i] !== exp_gate[i] || obs_valid[i] !== exp_valid[i] ||
                obs_ovf[i] !== exp_ovf[i] || obs_q[i] !== exp_q[i]) begin
                d++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return d;
    endfunction

    task automatic test_reset();
        logic [18:0] o;
        @(posedge CLK);
        nCLR = 1'b0;
        RUN  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge CLK);
            o = outs(i % 4);
            checks++;
            if (o !== 19'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d inst %0d: got %h expected 0", i, i % 4, o);
            end
            FX = 1'($urandom_range(0, 1));
        end
        RUN = 1'b0;
        FX  = 1'b0;
    endtask

    task automatic test_basic();
        int          nv;
        int          gate_hi;
        int          d;
        logic [15:0] q_seen;
        logic        ovf_seen;
        do_reset();
        clear_stim();
        add(1, 1'b0, 1'b0);
        add(1, 1'b1, 1'b0);
        add(4, 1'b0, 1'b0);
        add_pulses(37, 1, 1, 1'b0);
        add(40, 1'b0, 1'b0);
        model(G_A);
        drive_record(0);
        nv = 0; gate_hi = 0; q_seen = 'x; ovf_seen = 1'bx;
        foreach (obs_valid[i]) begin
            if (obs_valid[i] === 1'b1) begin
                nv++;
                q_seen   = obs_q[i];
                ovf_seen = obs_ovf[i];
            end
            if (obs_gate[i] === 1'b1) gate_hi++;
        end
        checks++;
        if (nv != 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", nv); end
        checks++;
        if (q_seen !== 16'h0037) begin errors++; $display("FAIL basic_q: got %h expected 0037", q_seen); end
        checks++;
        if (ovf_seen !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf_seen); end
        checks++;
        if (gate_hi != 100) begin errors++; $display("FAIL basic_gate_len: got %0d expected 100", gate_hi); end
        d = count_diffs();
        checks++;
        if (d != 0) begin errors++; $display("FAIL basic_trace: %0d cycles differ, first at %0d", d, first_bad); end
    endtask

    task automatic test_overflow();
        logic [15:0] qs[$];
        bit          os[$];
        int          d;
        do_reset();
        clear_stim();
        add(2, 1'b1, 1'b0);
        add_pulses(10003, 1, 1, 1'b1);
        add(94, 1'b1, 1'b0);
        add(1, 1'b1, 1'b0);
        add(4, 1'b0, 1'b0);
        add_pulses(5, 1, 1, 1'b0);
        add(20100, 1'b0, 1'b0);
        model(G_C);
        drive_record(2);
        foreach (obs_valid[i]) if (obs_valid[i] === 1'b1) begin qs.push_back(obs_q[i]); os.push_back(obs_ovf[i]); end
        checks++;
        if (qs.size() != 2) begin
            errors++; $display("FAIL ovf_valid_count: got %0d expected 2", qs.size());
        end else begin
            checks++;
            if (qs[0] !== 16'h0003 || os[0] !== 1'b1) begin
                errors++; $display("FAIL ovf_first: got q=%h ovf=%b expected q=0003 ovf=1", qs[0], os[0]);
            end
            checks++;
            if (qs[1] !== 16'h0005 || os[1] !== 1'b0) begin
                errors++; $display("FAIL ovf_second: got q=%h ovf=%b expected q=0005 ovf=0", qs[1], os[1]);
            end
        end
        d = count_diffs();
        checks++;
        if (d != 0) begin errors++; $display("FAIL ovf_trace: %0d cycles differ, first at %0d", d, first_bad); end
    endtask

    task automatic test_continuous();
        int vq[$];
        int g_after;
        int d;
        do_reset();
        clear_stim();
        add_random(40, 100);
        add_random(30, 0);
        model(G_B);
        drive_record(1);
        foreach (obs_valid[i]) if (obs_valid[i] === 1'b1) vq.push_back(i);
        checks++;
        if (vq.size() != 4) begin errors++; $display("FAIL cont_valid_count: got %0d expected 4", vq.size()); end
        for (int k = 0; k < vq.size(); k++) begin
            checks++;
            if (vq[k] != 12 * (k + 1)) begin
                errors++; $display("FAIL cont_valid_at[%0d]: got cycle %0d expected %0d", k, vq[k], 12 * (k + 1));
            end
        end
        g_after = 0;
        for (int i = 49; i < obs_gate.size(); i++) if (obs_gate[i] !== 1'b0) g_after++;
        checks++;
        if (g_after != 0) begin errors++; $display("FAIL cont_idle_gate: got %0d high cycles expected 0", g_after); end
        d = count_diffs();
        checks++;
        if (d != 0) begin errors++; $display("FAIL cont_trace: %0d cycles differ, first at %0d", d, first_bad); end
    endtask

    task automatic test_window_edges();
        int          nv;
        int          d;
        logic [15:0] q_seen;
        do_reset();
        clear_stim();
        add_random(15, 0);
        add(4, 1'b0, 1'b0);
        add(1, 1'b0, 1'b1);   // rise lands in the CLEAR cycle
        add(1, 1'b1, 1'b0);   // RUN at cycle 20, result at cycle 122
        add(99, 1'b0, 1'b0);
        add(1, 1'b0, 1'b1);   // rise lands in the LATCH cycle
        add(1, 1'b0, 1'b0);
        add(1, 1'b0, 1'b1);
        add(11, 1'b0, 1'b0);
        model(G_A);
        drive_record(0);
        nv = 0; q_seen = 'x;
        foreach (obs_valid[i]) if (obs_valid[i] === 1'b1) begin nv++; q_seen = obs_q[i]; end
        checks++;
        if (nv != 1) begin errors++; $display("FAIL edges_valid_count: got %0d expected 1", nv); end
        checks++;
        if (q_seen !== 16'h0000) begin errors++; $display("FAIL edges_q: got %h expected 0000", q_seen); end
        d = count_diffs();
        checks++;
        if (d != 0) begin errors++; $display("FAIL edges_trace: %0d cycles differ, first at %0d", d, first_bad); end
    endtask

    task automatic test_gate_one();
        int nv;
        int d;
        do_reset();
        clear_stim();
        add_random(60, 100);
        add_random(20, 0);
        model(G_D);
        drive_record(3);
        nv = 0;
        foreach (obs_valid[i]) if (obs_valid[i] === 1'b1) nv++;
        checks++;
        if (nv != 20) begin errors++; $display("FAIL g1_valid_count: got %0d expected 20", nv); end
        d = count_diffs();
        checks++;
        if (d != 0) begin errors++; $display("FAIL g1_trace: %0d cycles differ, first at %0d", d, first_bad); end
    endtask

    task automatic test_random_runs();
        int idx_l[3];
        int g_l[3];
        int nv;
        int ev;
        int d;
        idx_l = '{0, 1, 3};
        g_l   = '{int'(G_A), int'(G_B), int'(G_D)};
        for (int t = 0; t < 3; t++) begin
            do_reset();
            clear_stim();
            add_random(600, 75);
            model(g_l[t]);
            drive_record(idx_l[t]);
            nv = 0; ev = 0;
            foreach (obs_valid[i]) begin
                if (obs_valid[i] === 1'b1) nv++;
                if (exp_valid[i]) ev++;
            end
            checks++;
            if (nv != ev) begin errors++; $display("FAIL rand_valid_count[%0d]: got %0d expected %0d", t, nv, ev); end
            d = count_diffs();
            checks++;
            if (d != 0) begin errors++; $display("FAIL rand_trace[%0d]: %0d cycles differ, first at %0d", t, d, first_bad); end
        end
    endtask

    task automatic test_abort();
        logic [18:0] o;
        int          bad;
        do_reset();
        clear_stim();
        add(2, 1'b1, 1'b0);
        add_pulses(12, 1, 1, 1'b1);
        add(77, 1'b1, 1'b0);
        add(3, 1'b1, 1'b0);
        add_pulses(20, 1, 1, 1'b1);
        add(4, 1'b1, 1'b0);
        drive_record(0);
        checks++;
        if (obs_q[149] !== 16'h0012 || obs_gate[149] !== 1'b1) begin
            errors++; $display("FAIL abort_pre: got q=%h gate=%b expected q=0012 gate=1", obs_q[149], obs_gate[149]);
        end
        #2 nCLR = 1'b0;
        RUN = 1'b1;
        #1 o = outs(0);
        checks++;
        if (o !== 19'd0) begin errors++; $display("FAIL abort_immediate: got %h expected 0", o); end
        bad = 0;
        repeat (5) begin
            @(posedge CLK);
            if (outs(0) !== 19'd0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_hold: got %0d nonzero cycles expected 0", bad); end
        RUN  = 1'b0;
        nCLR = 1'b1;
        bad  = 0;
        repeat (4) begin
            @(posedge CLK);
            if (outs(0) !== 19'd0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_idle: got %0d nonzero cycles expected 0", bad); end
        RUN = 1'b1;
        @(posedge CLK);
        RUN = 1'b0;
        o = outs(0);
        checks++;
        if (o[18] !== 1'b0) begin errors++; $display("FAIL abort_clear_gate: got %b expected 0", o[18]); end
        @(posedge CLK);
        o = outs(0);
        checks++;
        if (o[18] !== 1'b1) begin errors++; $display("FAIL abort_restart_gate: got %b expected 1", o[18]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window_edges();
        test_continuous();
        test_gate_one();
        test_random_runs();
        test_abort();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
